// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART packet framer/deframer pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    typedef enum logic [2:0] {
        S_HUNT    = ST_HUNT,
        S_LEN     = ST_LEN,
        S_PAYLOAD = ST_PAYLOAD,
        S_CSUM    = ST_CSUM,
        S_DRAIN   = ST_DRAIN
    } pkt_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Running modulo-256 checksum step, shared with the TX framer.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_pkt_buf.sv
// ============================================================================
//  Module      : uart_pkt_buf
//  Description : Payload register file, one sync write port, one async read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pkt_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_pkt_deframer.sv
// ============================================================================
//  Module      : uart_pkt_deframer
//  Description : Hunts SYNC/LEN/payload/CSUM frames from the UART receiver and
//                releases verified payloads on a valid/ready byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pkt_deframer #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = uart_pkg::DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_Last,
    input  logic       i_Ready,
    output logic [7:0] o_Len,
    output logic       o_Err_Csum,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Overrun
);

    import uart_pkg::*;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    pkt_state_t       state, state_nxt;
    logic [7:0]       len, len_nxt;
    logic [7:0]       sum, sum_nxt;
    logic [7:0]       len_out, len_out_nxt;
    logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic             csum_err, csum_err_nxt;
    logic             len_err, len_err_nxt;
    logic             to_err, to_err_nxt;
    logic             overrun, overrun_nxt;
    logic             wr_en;
    logic [7:0]       rd_data;
    logic             valid;
    logic             last;

    uart_pkt_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (IDX_W)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    assign valid = (state == S_DRAIN);
    assign last  = valid && (8'(rd_idx) == len_out - 8'd1);

    assign o_Valid       = valid;
    assign o_Last        = last;
    assign o_Data        = valid ? rd_data : 8'd0;
    assign o_Len         = len_out;
    assign o_Err_Csum    = csum_err;
    assign o_Err_Len     = len_err;
    assign o_Err_Timeout = to_err;
    assign o_Overrun     = overrun;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state    <= S_HUNT;
            len      <= 8'd0;
            sum      <= 8'd0;
            len_out  <= 8'd0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            to_cnt   <= '0;
            csum_err <= 1'b0;
            len_err  <= 1'b0;
            to_err   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            sum      <= sum_nxt;
            len_out  <= len_out_nxt;
            wr_idx   <= wr_idx_nxt;
            rd_idx   <= rd_idx_nxt;
            to_cnt   <= to_cnt_nxt;
            csum_err <= csum_err_nxt;
            len_err  <= len_err_nxt;
            to_err   <= to_err_nxt;
            overrun  <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        sum_nxt      = sum;
        len_out_nxt  = len_out;
        wr_idx_nxt   = wr_idx;
        rd_idx_nxt   = rd_idx;
        to_cnt_nxt   = '0;
        csum_err_nxt = 1'b0;
        len_err_nxt  = 1'b0;
        to_err_nxt   = 1'b0;
        overrun_nxt  = 1'b0;
        wr_en        = 1'b0;

        case (state)
            S_HUNT: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_nxt = S_LEN;
                end
            end

            S_LEN, S_PAYLOAD, S_CSUM: begin
                // An arriving byte always beats a simultaneous expiry.
                if (i_Rx_DV) begin
                    if (state == S_LEN) begin
                        if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                            len_err_nxt = 1'b1;
                            state_nxt   = S_HUNT;
                        end else begin
                            len_nxt    = i_Rx_Byte;
                            sum_nxt    = i_Rx_Byte;
                            wr_idx_nxt = '0;
                            state_nxt  = S_PAYLOAD;
                        end
                    end else if (state == S_PAYLOAD) begin
                        wr_en   = 1'b1;
                        sum_nxt = csum_add(sum, i_Rx_Byte);
                        if (8'(wr_idx) == len - 8'd1) begin
                            state_nxt = S_CSUM;
                        end else begin
                            wr_idx_nxt = wr_idx + IDX_W'(1);
                        end
                    end else begin
                        if (i_Rx_Byte == sum) begin
                            len_out_nxt = len;
                            rd_idx_nxt  = '0;
                            state_nxt   = S_DRAIN;
                        end else begin
                            csum_err_nxt = 1'b1;
                            state_nxt    = S_HUNT;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    to_err_nxt = 1'b1;
                    state_nxt  = S_HUNT;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end

            S_DRAIN: begin
                // No look-ahead: anything received while draining is lost.
                overrun_nxt = i_Rx_DV;
                if (i_Ready) begin
                    if (last) begin
                        state_nxt = S_HUNT;
                    end else begin
                        rd_idx_nxt = rd_idx + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = S_HUNT;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_pkt_deframer.sv
// ============================================================================
//  Module      : tb_uart_pkt_deframer
//  Description : Directed self-checking bench for uart_pkt_deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_pkt_deframer;

    localparam int TO_CLKS = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;
    logic [7:0] len;
    logic       err_csum;
    logic       err_len;
    logic       err_to;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_pkt_deframer #(
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TO_CLKS)
    ) dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Data        (data),
        .o_Valid       (valid),
        .o_Last        (last),
        .i_Ready       (ready),
        .o_Len         (len),
        .o_Err_Csum    (err_csum),
        .o_Err_Len     (err_len),
        .o_Err_Timeout (err_to),
        .o_Overrun     (overrun)
    );

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid, last, data, len, err_csum, err_len, err_to, overrun} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got v%b l%b d%h len%h s%b%b%b%b exp all zero",
                     valid, last, data, len, err_csum, err_len, err_to, overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid, last, data, len} !== {1'b1, (i == 2), exp_d[i], 8'd3}) begin
                errors++;
                $display("FAIL good_beat%0d got v%b l%b d%h len%h exp v1 l%b d%h len03",
                         i, valid, last, data, len, (i == 2), exp_d[i]);
            end
            checks++;
            if ({err_csum, err_len, err_to, overrun} !== 4'b0) begin
                errors++;
                $display("FAIL good_strobes%0d got %b%b%b%b exp 0000", i, err_csum, err_len, err_to, overrun);
            end
            @(negedge clk);
        end
        checks++;
        if ({valid, last, data, len} !== {1'b0, 1'b0, 8'h00, 8'd3}) begin
            errors++;
            $display("FAIL good_end got v%b l%b d%h len%h exp v0 l0 d00 len03", valid, last, data, len);
        end
    endtask

    task automatic test_bad_csum;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
        checks++;
        if ({err_csum, valid} !== 2'b10) begin
            errors++;
            $display("FAIL csum_strobe got err%b v%b exp err1 v0", err_csum, valid);
        end
        @(negedge clk);
        checks++;
        if ({err_csum, valid} !== 2'b00) begin
            errors++;
            $display("FAIL csum_one_cycle got err%b v%b exp err0 v0", err_csum, valid);
        end
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h32);
        checks++;
        if ({valid, last, data, len} !== {1'b1, 1'b0, 8'h10, 8'd2}) begin
            errors++;
            $display("FAIL csum_recover0 got v%b l%b d%h len%h exp v1 l0 d10 len02", valid, last, data, len);
        end
        @(negedge clk);
        checks++;
        if ({valid, last, data} !== {1'b1, 1'b1, 8'h20}) begin
            errors++;
            $display("FAIL csum_recover1 got v%b l%b d%h exp v1 l1 d20", valid, last, data);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_len;
        send_byte(8'hA5); send_byte(8'h20);
        checks++;
        if ({err_len, err_csum} !== 2'b10) begin
            errors++;
            $display("FAIL len_too_big got err_len%b err_csum%b exp 1 0", err_len, err_csum);
        end
        send_byte(8'hA5);
        checks++;
        if (err_len !== 1'b0) begin
            errors++;
            $display("FAIL len_one_cycle got %b exp 0", err_len);
        end
        send_byte(8'h00);
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("FAIL len_zero got %b exp 1", err_len);
        end
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        checks++;
        if ({err_csum, err_len, err_to, overrun, valid} !== 5'b0) begin
            errors++;
            $display("FAIL garbage_silent got %b%b%b%b v%b exp all zero", err_csum, err_len, err_to, overrun, valid);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
        checks++;
        if ({valid, last, data, len} !== {1'b1, 1'b1, 8'h44, 8'd1}) begin
            errors++;
            $display("FAIL garbage_then_frame got v%b l%b d%h len%h exp v1 l1 d44 len01", valid, last, data, len);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int early;
        early = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        for (int i = 1; i < TO_CLKS; i++) begin
            @(negedge clk);
            if (err_to !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early got %0d early strobes exp 0", early);
        end
        @(negedge clk);
        checks++;
        if (err_to !== 1'b1) begin
            errors++;
            $display("FAIL timeout_strobe got %b exp 1", err_to);
        end
        @(negedge clk);
        checks++;
        if (err_to !== 1'b0) begin
            errors++;
            $display("FAIL timeout_one_cycle got %b exp 0", err_to);
        end
        // Remainder of the abandoned frame must be ignored in HUNT.
        send_byte(8'h22); send_byte(8'h35);
        checks++;
        if ({valid, err_csum} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_hunt got v%b csum%b exp v0 csum0", valid, err_csum);
        end
        // Byte on the expiry cycle continues the frame.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        repeat (TO_CLKS - 1) @(negedge clk);
        send_byte(8'h22);
        checks++;
        if (err_to !== 1'b0) begin
            errors++;
            $display("FAIL timeout_edge_byte got %b exp 0", err_to);
        end
        send_byte(8'h35);
        checks++;
        if ({valid, data, len} !== {1'b1, 8'h11, 8'd2}) begin
            errors++;
            $display("FAIL timeout_edge_frame got v%b d%h len%h exp v1 d11 len02", valid, data, len);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int bad;
        bad = 0;
        ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        @(negedge clk);
        ready = 1'b0;
        send_byte(8'hA5);
        checks++;
        if ({overrun, valid, data} !== {1'b1, 1'b1, 8'h22}) begin
            errors++;
            $display("FAIL overrun_strobe got ovr%b v%b d%h exp ovr1 v1 d22", overrun, valid, data);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if ({valid, last, data, overrun} !== {1'b1, 1'b0, 8'h22, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles exp 0", bad);
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, last, data} !== {1'b1, 1'b1, 8'h33}) begin
            errors++;
            $display("FAIL stall_resume got v%b l%b d%h exp v1 l1 d33", valid, last, data);
        end
        @(negedge clk);
        checks++;
        if ({valid, data} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL stall_end got v%b d%h exp v0 d00", valid, data);
        end
    endtask

    task automatic test_reset_mid_drain;
        ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h05);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, last, data, len, err_csum, err_len, err_to, overrun} !== 20'h0) begin
            errors++;
            $display("FAIL reset_async got v%b l%b d%h len%h exp all zero", valid, last, data, len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        checks++;
        if ({valid, last, data, len, err_csum} !== {1'b1, 1'b1, 8'h7E, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset_recover got v%b l%b d%h len%h csum%b exp v1 l1 d7e len01 csum0",
                     valid, last, data, len, err_csum);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover_end got v%b exp 0", valid);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_csum;
        test_bad_len;
        test_timeout;
        test_backpressure;
        test_reset_mid_drain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

`default_nettype wire
